md_ctrl: RTL and testbench
==========================

Name: md_ctrl

Overview:
- Multiply/divide controller for the CPU execute stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO ops from decode and owns the architectural HI/LO registers.
- Sequences the existing combinational MUL block over a fixed multi-cycle budget and runs an internal iterative radix-2 divider.
- Raises busy so the pipeline stalls until the result is committed.

Parameters:
- MUL_LAT, default 2: cycles the MUL result is allowed to settle before capture. Legal range 1..8.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- op_valid  input  1  op request; sampled only when the state is IDLE
- op  input  3  op code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD (see Optional Feature)
- src_a  input  32  rs operand: multiplicand, dividend, or MTHI/MTLO data
- src_b  input  32  rt operand: multiplier or divisor
- flush  input  1  pipeline flush; aborts any in-flight op
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse when a result commits
- div_zero  output  1  pulses with done for DIV/DIVU with src_b == 0
- hi  output  32  architectural HI register
- lo  output  32  architectural LO register

Behaviour:
- Reset (async, any state): hi=0, lo=0, busy=0, done=0, div_zero=0; state=IDLE; all counters and operand registers cleared.
- Accept: op_valid=1 && state==IDLE && flush==0 && op!=NOP at edge N.
  - src_a, src_b and the sign mode are latched into internal registers.
  - The MUL instance is driven only from these latched registers, never directly from the ports.
- States: IDLE, MUL, DIV, FIX.
- MTHI/MTLO: hi or lo written at edge N; no busy; done=1 in cycle N+1.
- MULT/MULTU:
  - IDLE->MUL; busy high for MUL_LAT cycles.
  - {hi,lo} <= MUL {HI,LO} on the edge where the counter reaches MUL_LAT-1; state returns to IDLE on that edge.
  - done=1 in the first cycle after busy falls; new hi/lo are visible in that same cycle.
  - sign_flag=1 for MULT, 0 for MULTU.
- DIV/DIVU:
  - IDLE->DIV; 32 restoring iterations on operand magnitudes (DIVU uses raw operands), one bit per cycle.
  - DIV->FIX; FIX applies signs:
    - quotient is negated when the operand signs differ;
    - remainder takes the sign of the dividend.
  - lo<=quotient, hi<=remainder at the FIX edge. busy lasts 33 cycles; done follows.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag.
- Divide by zero: no iteration. busy for 1 cycle; hi/lo unchanged; done and div_zero pulse together.
- Requests while busy: ignored and not queued. The issuer must hold the op until busy=0.
- flush while busy: next edge -> IDLE; hi/lo unchanged; no done.
- flush with op_valid in IDLE: flush wins; the op is dropped, including MTHI/MTLO.
- Reset mid-operation: immediate abort to reset values.
- op=NOP with op_valid: no effect.

Optional Feature:
- Macro MD_CTRL_MADD_EN.
- When defined: op 7 = MADD. Signed product via the MUL path (same MUL_LAT timing); {hi,lo} <= {hi,lo} + product, 64-bit wrap-around.
- When undefined: op 7 is treated as NOP; no adder is synthesized.

Test Plan:
- MULT 0xF x 0x7, MUL_LAT=2 -> busy 2 cycles; hi=0x00000000, lo=0x00000069; done 1 cycle.
- MULT vs MULTU with 0xFFFFFFFF x 0x2 -> signed: hi=0xFFFFFFFF, lo=0xFFFFFFFE; unsigned: hi=0x00000001, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 0x2 -> busy 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIVU 5/0 with prior hi=0x11, lo=0x22 -> busy 1 cycle; done and div_zero pulse; hi/lo unchanged.
- Start DIV, assert flush at busy cycle 10 -> busy=0 next cycle; no done; hi/lo unchanged. An op_valid held during busy is ignored.
- MTHI 0xDEADBEEF then MADD (macro on) 0x2 x 0x3 with lo=0xFFFFFFFF -> hi=0xDEADBEF0, lo=0x00000005. With the macro off, op 7 leaves hi/lo unchanged.

Source files
------------

// File: rtl/md_ctrl_if.sv
// md_ctrl_if: decode-side request bus and HI/LO result bus of the mul/div controller.
interface md_ctrl_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op, src_a, src_b, flush,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide controller owning the architectural HI/LO registers.
// Multiplies run through a combinational product held for MUL_LAT cycles;
// divides use a 32-step restoring divider followed by a sign-fixup cycle.
// Optional: define MD_CTRL_MADD_EN to enable op 7 (MADD, signed
// multiply-accumulate into {hi,lo}); otherwise op 7 behaves as NOP.
module md_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic     clk,
  input  logic     rst,
  md_ctrl_if.slave bus
);

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CW        = 5;
  localparam int unsigned DIV_ITERS = 32;

  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_ITERS - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MD_CTRL_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd7;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic              r_sign;
  logic              r_dz;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_busy;
  logic              r_done;
  logic              r_div_zero;
`ifdef MD_CTRL_MADD_EN
  logic              r_madd;
`endif

  logic [2*XLEN-1:0] w_ext_a;
  logic [2*XLEN-1:0] w_ext_b;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN-1:0]   w_src_a_mag;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_trial;
  logic              w_quo_neg;
  logic              w_rem_neg;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
`ifdef MD_CTRL_MADD_EN
  logic [2*XLEN-1:0] w_acc;
`endif

  // Multiplier operands come only from the latched registers; sign mode picks extension.
  assign w_ext_a = r_sign ? {{XLEN{r_a[XLEN-1]}}, r_a} : {{XLEN{1'b0}}, r_a};
  assign w_ext_b = r_sign ? {{XLEN{r_b[XLEN-1]}}, r_b} : {{XLEN{1'b0}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

`ifdef MD_CTRL_MADD_EN
  assign w_acc = {r_hi, r_lo} + w_prod;
`endif

  // Divider datapath: magnitudes, one restoring trial subtraction per cycle, sign fixup.
  assign w_b_mag     = (r_sign && r_b[XLEN-1]) ? XLEN'(-r_b) : r_b;
  assign w_src_a_mag = ((bus.op == OP_DIV) && bus.src_a[XLEN-1]) ? XLEN'(-bus.src_a) : bus.src_a;
  assign w_shift     = {r_rem, r_quo[XLEN-1]};
  assign w_trial     = w_shift - {1'b0, w_b_mag};
  assign w_quo_neg   = r_sign & (r_a[XLEN-1] ^ r_b[XLEN-1]);
  assign w_rem_neg   = r_sign & r_a[XLEN-1];
  assign w_quo_fix   = w_quo_neg ? XLEN'(-r_quo) : r_quo;
  assign w_rem_fix   = w_rem_neg ? XLEN'(-r_rem) : r_rem;

  // Control FSM, operand latching, divider iteration and HI/LO commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_sign     <= 1'b0;
      r_dz       <= 1'b0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
`ifdef MD_CTRL_MADD_EN
      r_madd     <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.op_valid && !bus.flush) begin
            case (bus.op)
              OP_MTHI: begin
                r_hi   <= bus.src_a;
                r_done <= 1'b1;
              end
              OP_MTLO: begin
                r_lo   <= bus.src_a;
                r_done <= 1'b1;
              end
              OP_MULT, OP_MULTU: begin
                r_a     <= bus.src_a;
                r_b     <= bus.src_b;
                r_sign  <= (bus.op == OP_MULT);
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_state <= ST_MUL;
`ifdef MD_CTRL_MADD_EN
                r_madd  <= 1'b0;
`endif
              end
`ifdef MD_CTRL_MADD_EN
              OP_MADD: begin
                r_a     <= bus.src_a;
                r_b     <= bus.src_b;
                r_sign  <= 1'b1;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_state <= ST_MUL;
                r_madd  <= 1'b1;
              end
`endif
              OP_DIV, OP_DIVU: begin
                r_a    <= bus.src_a;
                r_b    <= bus.src_b;
                r_sign <= (bus.op == OP_DIV);
                r_cnt  <= '0;
                r_rem  <= '0;
                r_quo  <= w_src_a_mag;
                r_busy <= 1'b1;
                if (bus.src_b == '0) begin
                  // Zero divisor skips iteration and only flags in the fixup cycle.
                  r_dz    <= 1'b1;
                  r_state <= ST_FIX;
                end else begin
                  r_dz    <= 1'b0;
                  r_state <= ST_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (bus.flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == MUL_LAST) begin
`ifdef MD_CTRL_MADD_EN
            if (r_madd) {r_hi, r_lo} <= w_acc;
            else        {r_hi, r_lo} <= w_prod;
`else
            {r_hi, r_lo} <= w_prod;
`endif
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DIV: begin
          if (bus.flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (!w_trial[XLEN]) begin
              r_rem <= w_trial[XLEN-1:0];
              r_quo <= {r_quo[XLEN-2:0], 1'b1};
            end else begin
              r_rem <= w_shift[XLEN-1:0];
              r_quo <= {r_quo[XLEN-2:0], 1'b0};
            end
            if (r_cnt == DIV_LAST) r_state <= ST_FIX;
            else                   r_cnt   <= r_cnt + 1'b1;
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (!bus.flush) begin
            r_done <= 1'b1;
            if (r_dz) begin
              r_div_zero <= 1'b1;
            end else begin
              r_lo <= w_quo_fix;
              r_hi <= w_rem_fix;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: scoreboard bench for the mul/div controller (optional MADD via MD_CTRL_MADD_EN).
module tb_md_ctrl;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned DIV_BUSY = 33;
  localparam int unsigned TIMEOUT = 200;

  logic clk = 1'b0;
  logic rst;

  md_ctrl_if bus();

  md_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int unsigned busy;
  } vec_t;

  vec_t sb[$];

  int checks   = 0;
  int failures = 0;

  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_dz;
  logic        o_seen;
  logic        o_done_next;
  int unsigned o_busy;

  function automatic vec_t mk(string n, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] hi, logic [31:0] lo, logic dz, int unsigned busy);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b;
    v.hi = hi; v.lo = lo; v.dz = dz; v.busy = busy;
    return v;
  endfunction

  task automatic do_reset();
    bus.op_valid = 1'b0; bus.op = 3'd0; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one op for a single accept edge, then drop op_valid.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0; bus.op = 3'd0;
  endtask

  // Observe until done: count busy cycles, capture results, sample done one cycle later.
  task automatic collect();
    o_seen = 1'b0; o_busy = 0; o_done_next = 1'b0;
    o_hi = '0; o_lo = '0; o_dz = 1'b0;
    for (int i = 0; i < int'(TIMEOUT) && !o_seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        o_seen = 1'b1; o_hi = bus.hi; o_lo = bus.lo; o_dz = bus.div_zero;
      end else if (bus.busy) begin
        o_busy++;
      end
    end
    if (o_seen) begin
      @(negedge clk);
      o_done_next = bus.done;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.op_valid = 1'b0; bus.op = 3'd0; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.div_zero !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", bus.div_zero); end
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    rst = 1'b0;
    // Mid-operation reset: load HI, start a divide, then reset asynchronously.
    issue(3'd5, 32'h0000_0077, 32'h0);
    collect();
    issue(3'd3, 32'd1000, 32'd7);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL midrst_hi got=%h exp=0", bus.hi); end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.lo !== 32'h0) begin
      failures++; $display("FAIL midrst_after busy=%b lo=%h exp busy=0 lo=0", bus.busy, bus.lo);
    end
  endtask

  task automatic test_mul();
    vec_t v[$];
    vec_t e;
    do_reset();
    v.push_back(mk("mult_f_7",    3'd1, 32'h0000_000F, 32'h0000_0007, 32'h0000_0000, 32'h0000_0069, 1'b0, MUL_LAT));
    v.push_back(mk("mult_m1_2",   3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, MUL_LAT));
    v.push_back(mk("multu_m1_2",  3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, MUL_LAT));
    v.push_back(mk("mult_min_sq", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, MUL_LAT));
    v.push_back(mk("multu_max",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MUL_LAT));
    foreach (v[i]) begin
      sb.push_back(v[i]);
      issue(v[i].op, v[i].a, v[i].b);
      collect();
      e = sb.pop_front();
      checks++; if (o_seen !== 1'b1) begin failures++; $display("FAIL %s done not seen in %0d cycles", e.name, TIMEOUT); end
      checks++; if (o_hi !== e.hi) begin failures++; $display("FAIL %s hi got=%h exp=%h", e.name, o_hi, e.hi); end
      checks++; if (o_lo !== e.lo) begin failures++; $display("FAIL %s lo got=%h exp=%h", e.name, o_lo, e.lo); end
      checks++; if (o_dz !== e.dz) begin failures++; $display("FAIL %s div_zero got=%b exp=%b", e.name, o_dz, e.dz); end
      checks++; if (o_busy !== e.busy) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", e.name, o_busy, e.busy); end
      checks++; if (o_done_next !== 1'b0) begin failures++; $display("FAIL %s done_width got=%b exp=0", e.name, o_done_next); end
    end
  endtask

  task automatic test_div();
    vec_t v[$];
    vec_t e;
    do_reset();
    v.push_back(mk("div_m7_2",    3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_BUSY));
    v.push_back(mk("divu_100_7",  3'd4, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, DIV_BUSY));
    v.push_back(mk("div_ovf",     3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, DIV_BUSY));
    v.push_back(mk("div_7_m2",    3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, DIV_BUSY));
    v.push_back(mk("divu_big",    3'd4, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, DIV_BUSY));
    v.push_back(mk("mthi_11",     3'd5, 32'h0000_0011, 32'h0,         32'h0000_0011, 32'h0FFF_FFFF, 1'b0, 0));
    v.push_back(mk("mtlo_22",     3'd6, 32'h0000_0022, 32'h0,         32'h0000_0011, 32'h0000_0022, 1'b0, 0));
    v.push_back(mk("divu_5_0",    3'd4, 32'd5,         32'd0,         32'h0000_0011, 32'h0000_0022, 1'b1, 1));
    v.push_back(mk("div_5_0",     3'd3, 32'hFFFF_FFFB, 32'd0,         32'h0000_0011, 32'h0000_0022, 1'b1, 1));
    foreach (v[i]) begin
      sb.push_back(v[i]);
      issue(v[i].op, v[i].a, v[i].b);
      collect();
      e = sb.pop_front();
      checks++; if (o_seen !== 1'b1) begin failures++; $display("FAIL %s done not seen in %0d cycles", e.name, TIMEOUT); end
      checks++; if (o_hi !== e.hi) begin failures++; $display("FAIL %s hi got=%h exp=%h", e.name, o_hi, e.hi); end
      checks++; if (o_lo !== e.lo) begin failures++; $display("FAIL %s lo got=%h exp=%h", e.name, o_lo, e.lo); end
      checks++; if (o_dz !== e.dz) begin failures++; $display("FAIL %s div_zero got=%b exp=%b", e.name, o_dz, e.dz); end
      checks++; if (o_busy !== e.busy) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", e.name, o_busy, e.busy); end
      checks++; if (o_done_next !== 1'b0) begin failures++; $display("FAIL %s done_width got=%b exp=0", e.name, o_done_next); end
    end
  endtask

  task automatic test_flush();
    int done_seen;
    do_reset();
    issue(3'd5, 32'hA5A5_0001, 32'h0);
    collect();
    issue(3'd6, 32'h5A5A_0002, 32'h0);
    collect();
    issue(3'd3, 32'd1000, 32'd3);
    // Hold a competing MTHI request through the busy window; it must be ignored.
    bus.op_valid = 1'b1; bus.op = 3'd5; bus.src_a = 32'hBAD0_BAD0;
    repeat (10) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL flush_busy10 got=%b exp=1", bus.busy); end
    bus.flush = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_busy_drop got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL flush_done got=%b exp=0", bus.done); end
    bus.op_valid = 1'b0; bus.op = 3'd0;
    @(negedge clk);
    bus.flush = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    checks++; if (done_seen !== 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", done_seen); end
    checks++; if (bus.hi !== 32'hA5A5_0001) begin failures++; $display("FAIL flush_hi got=%h exp=a5a50001", bus.hi); end
    checks++; if (bus.lo !== 32'h5A5A_0002) begin failures++; $display("FAIL flush_lo got=%h exp=5a5a0002", bus.lo); end
  endtask

  task automatic test_flush_idle();
    // flush alongside an MTLO in IDLE drops the op; a NOP request does nothing.
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 3'd6; bus.src_a = 32'h1234_5678; bus.flush = 1'b1;
    @(negedge clk);
    bus.op_valid = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL flush_idle_done got=%b exp=0", bus.done); end
    checks++; if (bus.lo !== 32'h5A5A_0002) begin failures++; $display("FAIL flush_idle_lo got=%h exp=5a5a0002", bus.lo); end
    bus.op_valid = 1'b1; bus.op = 3'd0; bus.src_a = 32'hFFFF_0000;
    @(negedge clk);
    bus.op_valid = 1'b0;
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL nop_effect done=%b busy=%b exp 0/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_madd();
    vec_t v[$];
    vec_t e;
    do_reset();
    v.push_back(mk("mtlo_ffff", 3'd6, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0));
    v.push_back(mk("mthi_dead", 3'd5, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 0));
`ifdef MD_CTRL_MADD_EN
    v.push_back(mk("madd_2_3",  3'd7, 32'd2,         32'd3,        32'hDEAD_BEF0, 32'h0000_0005, 1'b0, MUL_LAT));
    v.push_back(mk("madd_m1_1", 3'd7, 32'hFFFF_FFFF, 32'd1,        32'hDEAD_BEF0, 32'h0000_0004, 1'b0, MUL_LAT));
`endif
    foreach (v[i]) begin
      sb.push_back(v[i]);
      issue(v[i].op, v[i].a, v[i].b);
      collect();
      e = sb.pop_front();
      checks++; if (o_seen !== 1'b1) begin failures++; $display("FAIL %s done not seen in %0d cycles", e.name, TIMEOUT); end
      checks++; if (o_hi !== e.hi) begin failures++; $display("FAIL %s hi got=%h exp=%h", e.name, o_hi, e.hi); end
      checks++; if (o_lo !== e.lo) begin failures++; $display("FAIL %s lo got=%h exp=%h", e.name, o_lo, e.lo); end
      checks++; if (o_dz !== e.dz) begin failures++; $display("FAIL %s div_zero got=%b exp=%b", e.name, o_dz, e.dz); end
      checks++; if (o_busy !== e.busy) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", e.name, o_busy, e.busy); end
      checks++; if (o_done_next !== 1'b0) begin failures++; $display("FAIL %s done_width got=%b exp=0", e.name, o_done_next); end
    end
`ifndef MD_CTRL_MADD_EN
    begin
      int act;
      issue(3'd7, 32'd2, 32'd3);
      act = 0;
      repeat (6) begin
        @(negedge clk);
        if (bus.busy || bus.done) act++;
      end
      checks++; if (act !== 0) begin failures++; $display("FAIL op7_nop_activity got=%0d exp=0", act); end
      checks++; if (bus.hi !== 32'hDEAD_BEEF) begin failures++; $display("FAIL op7_nop_hi got=%h exp=deadbeef", bus.hi); end
      checks++; if (bus.lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL op7_nop_lo got=%h exp=ffffffff", bus.lo); end
    end
`endif
  endtask

  task automatic test_back_to_back();
    vec_t v;
    vec_t e;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    longint      qa;
    longint      qb;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 32'h0) b = 32'h1;
      case (op)
        3'd1:    p = 64'(longint'($signed(a)) * longint'($signed(b)));
        3'd2:    p = {32'h0, a} * {32'h0, b};
        3'd3: begin
          qa = longint'($signed(a));
          qb = longint'($signed(b));
          p  = {32'(qa % qb), 32'(qa / qb)};
        end
        default: p = {a % b, a / b};
      endcase
      v = mk($sformatf("rand%0d_op%0d", i, op), op, a, b, p[63:32], p[31:0], 1'b0,
             (op <= 3'd2) ? MUL_LAT : DIV_BUSY);
      sb.push_back(v);
      issue(v.op, v.a, v.b);
      collect();
      e = sb.pop_front();
      checks++; if (o_seen !== 1'b1) begin failures++; $display("FAIL %s done not seen in %0d cycles", e.name, TIMEOUT); end
      checks++; if (o_hi !== e.hi) begin failures++; $display("FAIL %s a=%h b=%h hi got=%h exp=%h", e.name, e.a, e.b, o_hi, e.hi); end
      checks++; if (o_lo !== e.lo) begin failures++; $display("FAIL %s a=%h b=%h lo got=%h exp=%h", e.name, e.a, e.b, o_lo, e.lo); end
      checks++; if (o_busy !== e.busy) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", e.name, o_busy, e.busy); end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_flush();
    test_flush_idle();
    test_madd();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
